// File: rtl/gpr_scoreboard_file.sv
// General-purpose register file with N read ports, optional same-cycle write bypass,
// and a per-register busy scoreboard that requests a stall for operands still in flight.
module gpr_scoreboard_file #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int READ_PORTS = 3,
  parameter int BYPASS     = 1,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS),
  localparam int CNT_WIDTH  = $clog2(NUM_REGS + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           write_enable,
  input  logic [ADDR_WIDTH-1:0]          write_address,
  input  logic [DATA_WIDTH-1:0]          write_data,
  input  logic [READ_PORTS-1:0]          read_valid,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_address,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
  input  logic                           reserve_enable,
  input  logic [ADDR_WIDTH-1:0]          reserve_address,
  input  logic                           flush,
  output logic                           stall,
  output logic [CNT_WIDTH-1:0]           busy_count
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [NUM_REGS-1:0]   wr_hit, rsv_hit;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  cnt_inc, cnt_dec;

  logic [ADDR_WIDTH-1:0] rd_addr   [READ_PORTS];
  logic [DATA_WIDTH-1:0] rd_val    [READ_PORTS];
  logic                  rd_busy   [READ_PORTS];
  logic                  rd_fwd    [READ_PORTS];
  logic                  rd_in_rng [READ_PORTS];

  // One-hot decode; addresses at or beyond NUM_REGS match no register and are ignored.
  always_comb begin
    wr_hit  = '0;
    rsv_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      wr_hit[r]  = write_enable   && (write_address   == ADDR_WIDTH'(r));
      rsv_hit[r] = reserve_enable && (reserve_address == ADDR_WIDTH'(r));
    end
  end

  // A reserve outranks a same-cycle write to the same register: that write retires the older producer.
  always_comb begin
    cnt_inc = |(rsv_hit & ~busy_q);
    cnt_dec = |(wr_hit & busy_q & ~rsv_hit);
    busy_d  = (busy_q & ~wr_hit) | rsv_hit;
    count_d = count_q + CNT_WIDTH'(cnt_inc) - CNT_WIDTH'(cnt_dec);
    if (flush) begin
      busy_d  = '0;
      count_d = '0;
    end
  end

  // NOTE: the register array is reset along with the scoreboard so reads after reset return zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every state update sampling pre-edge values.
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_hit[r]) regs_q[r] <= write_data;
      end
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // NOTE: every variable below gets a default before the loops, so no latch is inferred.
  always_comb begin
    stall     = 1'b0;
    read_data = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_addr[p]   = read_address[p*ADDR_WIDTH +: ADDR_WIDTH];
      rd_val[p]    = '0;
      rd_busy[p]   = 1'b0;
      rd_in_rng[p] = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (rd_addr[p] == ADDR_WIDTH'(r)) begin
          rd_val[p]    = regs_q[r];
          rd_busy[p]   = busy_q[r];
          rd_in_rng[p] = 1'b1;
        end
      end
      rd_fwd[p] = (BYPASS != 0) && write_enable && rd_in_rng[p] &&
                  (write_address == rd_addr[p]);
      if (rd_fwd[p]) rd_val[p] = write_data;
      read_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_val[p];
      if (read_valid[p] && rd_busy[p] && !rd_fwd[p]) stall = 1'b1;
    end
  end

  assign busy_count = count_q;

endmodule

// File: tb/tb_gpr_scoreboard_file.sv
// Drives two configurations of gpr_scoreboard_file from shared stimulus (8 regs/3 ports/bypass and
// 6 regs/4 ports/no bypass) and compares every output against an array-based reference model.
module tb_gpr_scoreboard_file;

  logic        clock = 1'b0;
  logic        reset;
  logic        we, res, flush;
  logic [2:0]  wa, rsa;
  logic [15:0] wd;
  logic [2:0]  ra [4];
  logic [3:0]  rv;

  logic [8:0]  ra_a;
  logic [11:0] ra_b;
  logic [47:0] rd_a;
  logic [63:0] rd_b;
  logic        st_a, st_b;
  logic [3:0]  bc_a;
  logic [2:0]  bc_b;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_regs [2][8];
  bit          m_busy [2][8];

  always #5 clock = ~clock;

  assign ra_a = {ra[2], ra[1], ra[0]};
  assign ra_b = {ra[3], ra[2], ra[1], ra[0]};

  gpr_scoreboard_file #(.DATA_WIDTH(16), .NUM_REGS(8), .READ_PORTS(3), .BYPASS(1)) dut_a (
    .clock(clock), .reset(reset), .write_enable(we), .write_address(wa), .write_data(wd),
    .read_valid(rv[2:0]), .read_address(ra_a), .read_data(rd_a),
    .reserve_enable(res), .reserve_address(rsa), .flush(flush),
    .stall(st_a), .busy_count(bc_a));

  gpr_scoreboard_file #(.DATA_WIDTH(16), .NUM_REGS(6), .READ_PORTS(4), .BYPASS(0)) dut_b (
    .clock(clock), .reset(reset), .write_enable(we), .write_address(wa), .write_data(wd),
    .read_valid(rv), .read_address(ra_b), .read_data(rd_b),
    .reserve_enable(res), .reserve_address(rsa), .flush(flush),
    .stall(st_b), .busy_count(bc_b));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int nregs(int c);
    return (c == 0) ? 8 : 6;
  endfunction

  function automatic int nports(int c);
    return (c == 0) ? 3 : 4;
  endfunction

  function automatic bit byp(int c);
    return c == 0;
  endfunction

  function automatic logic [15:0] exp_rd(int c, int p);
    int a = int'(ra[p]);
    if (a >= nregs(c)) return 16'h0;
    if (byp(c) && we && int'(wa) == a) return wd;
    return m_regs[c][a];
  endfunction

  function automatic bit exp_stall(int c);
    for (int p = 0; p < nports(c); p++) begin
      int a = int'(ra[p]);
      if (rv[p] && a < nregs(c) && m_busy[c][a] && !(byp(c) && we && int'(wa) == a))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int exp_cnt(int c);
    int n = 0;
    for (int r = 0; r < nregs(c); r++) n += int'(m_busy[c][r]);
    return n;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 8; r++) begin
        m_regs[c][r] = 16'h0;
        m_busy[c][r] = 1'b0;
      end
  endtask

  task automatic model_clock();
    for (int c = 0; c < 2; c++) begin
      if (we && int'(wa) < nregs(c)) m_regs[c][wa] = wd;
      if (flush) begin
        for (int r = 0; r < 8; r++) m_busy[c][r] = 1'b0;
      end else begin
        if (we && int'(wa) < nregs(c)) m_busy[c][wa] = 1'b0;
        if (res && int'(rsa) < nregs(c)) m_busy[c][rsa] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < 3; p++)
      check($sformatf("A.rd%0d", p), 64'(rd_a[p*16 +: 16]), 64'(exp_rd(0, p)));
    for (int p = 0; p < 4; p++)
      check($sformatf("B.rd%0d", p), 64'(rd_b[p*16 +: 16]), 64'(exp_rd(1, p)));
    check("A.stall", 64'(st_a), 64'(exp_stall(0)));
    check("B.stall", 64'(st_b), 64'(exp_stall(1)));
    check("A.count", 64'(bc_a), 64'(exp_cnt(0)));
    check("B.count", 64'(bc_b), 64'(exp_cnt(1)));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    we = 0; wa = 0; wd = 0; res = 0; rsa = 0; flush = 0; rv = 0;
    for (int p = 0; p < 4; p++) ra[p] = 0;
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge clock);
    model_clock();
    #1;
  endtask

  task automatic async_reset_pulse();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    model_reset();
    #12;
    check_all();
    check("rst.count", 64'(bc_a), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Write r3 and reserve r1, then read r3 back from the array.
    we = 1; wa = 3; wd = 16'h1234; res = 1; rsa = 1;
    settle(); tick();
    idle(); ra[0] = 3;
    settle();
    check("wr.r3", 64'(rd_a[15:0]), 64'h1234);
    check("wr.count", 64'(bc_a), 64'd1);
    async_reset_pulse();
    check("arst.rd0", 64'(rd_a[15:0]), 64'h0);
    check("arst.count", 64'(bc_a), 64'd0);

    // Same-cycle bypass on port 2.
    @(posedge clock); #1;
    idle(); we = 1; wa = 5; wd = 16'hBEEF; ra[2] = 5;
    settle();
    check("byp.A", 64'(rd_a[47:32]), 64'hBEEF);
    check("byp.B", 64'(rd_b[47:32]), 64'h0000);
    tick();

    // Reserve r2, read it as a valid operand for 3 cycles, then clear it.
    idle(); res = 1; rsa = 2;
    settle(); tick();
    idle(); rv[1] = 1; ra[1] = 2;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("rsv.stall", 64'(st_a), 64'd1);
      check("rsv.count", 64'(bc_a), 64'd1);
      tick();
    end
    we = 1; wa = 2; wd = 16'h00AA;
    settle();
    check("clr.stallA", 64'(st_a), 64'd0);
    check("clr.dataA", 64'(rd_a[31:16]), 64'h00AA);
    check("clr.stallB", 64'(st_b), 64'd1);
    tick();
    we = 0;
    settle();
    check("clr.count", 64'(bc_a), 64'd0);
    check("clr.stallB1", 64'(st_b), 64'd0);
    tick();

    // Reserve and write of the same register in one cycle: reserve wins.
    idle(); res = 1; rsa = 4; we = 1; wa = 4; wd = 16'h0007;
    settle(); tick();
    idle(); ra[0] = 4;
    settle();
    check("same.data", 64'(rd_a[15:0]), 64'h0007);
    check("same.count", 64'(bc_a), 64'd1);
    we = 1; wa = 4; wd = 16'h0008;
    tick();
    idle();
    settle();
    check("same.clr", 64'(bc_a), 64'd0);

    // Successive reserves, a WAW re-reserve, then flush against a reserve.
    for (int i = 0; i < 3; i++) begin
      idle(); res = 1; rsa = (i == 0) ? 3'd1 : (i == 1) ? 3'd6 : 3'd7;
      tick();
      settle();
      check($sformatf("cnt.%0d", i), 64'(bc_a), 64'(i + 1));
    end
    idle(); res = 1; rsa = 6;
    tick(); settle();
    check("waw.count", 64'(bc_a), 64'd3);
    idle(); flush = 1; res = 1; rsa = 0;
    tick();
    idle(); ra[0] = 5; rv = 4'b1111; ra[1] = 1; ra[2] = 6;
    settle();
    check("flush.count", 64'(bc_a), 64'd0);
    check("flush.stall", 64'(st_a), 64'd0);
    check("flush.dataA", 64'(rd_a[15:0]), 64'hBEEF);
    check("flush.dataB", 64'(rd_b[15:0]), 64'hBEEF);

    // Out-of-range accesses on the 6-register instance, and per-port stall gating.
    idle(); we = 1; wa = 7; wd = 16'h5555; res = 1; rsa = 3;
    tick();
    idle(); ra[0] = 7;
    settle();
    check("oor.B", 64'(rd_b[15:0]), 64'h0);
    check("oor.A", 64'(rd_a[15:0]), 64'h5555);
    ra[0] = 0; ra[1] = 1; ra[2] = 2; ra[3] = 3; rv = 4'b1000;
    settle();
    check("port3.stall", 64'(st_b), 64'd1);
    rv = 4'b0000;
    settle();
    check("port3.idle", 64'(st_b), 64'd0);
    tick();

    // Randomised traffic against the model, with occasional asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      we    = ($urandom_range(0, 1) == 1);
      wa    = 3'($urandom_range(0, 7));
      wd    = 16'($urandom);
      res   = ($urandom_range(0, 2) == 0);
      rsa   = 3'($urandom_range(0, 7));
      flush = ($urandom_range(0, 15) == 0);
      rv    = 4'($urandom);
      for (int p = 0; p < 4; p++) ra[p] = 3'($urandom_range(0, 7));
      settle();
      if ($urandom_range(0, 63) == 0) async_reset_pulse();
      else tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
